// File: rtl/csa_accum.sv
// csa_accum: streaming carry-save accumulator.
// Accepts one WIDTH-bit operand per cycle into a redundant (sum, carry) pair
// built from a row of 3:2 compressors. The last beat of a group triggers a
// one-cycle carry-propagate add; the resolved sum and a saturating beat count
// are then offered on a valid/ready output.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   stage can accept an operand this cycle
//   in_data    operand value, unsigned
//   in_last    final operand of the current group
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_sum    resolved group sum, modulo 2^WIDTH
//   out_cnt    operands in the group, saturating at 2^CNT_W-1
module csa_accum #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt
);

  typedef enum logic [1:0] {
    ACC,
    RESOLVE,
    OUT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_cnt;

  logic             w_accept;
  logic [WIDTH-1:0] w_carry_sh;
  logic [WIDTH-1:0] w_sum_nxt;
  logic [WIDTH-1:0] w_carry_nxt;
  logic [WIDTH-1:0] w_resolved;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_accept = in_valid & r_in_ready;

  // Carry vector enters the next row with weight 2; its top bit falls off
  // because the accumulator is modulo 2^WIDTH.
  assign w_carry_sh = {r_carry[WIDTH-2:0], 1'b0};

  // Row of 3:2 compressors: operand, stored sum, shifted stored carry.
  assign w_sum_nxt   = in_data ^ r_sum ^ w_carry_sh;
  assign w_carry_nxt = (in_data & r_sum) | (in_data & w_carry_sh) | (r_sum & w_carry_sh);

  assign w_resolved = r_sum + w_carry_sh;

  assign w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACC;
      r_sum       <= '0;
      r_carry     <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cnt   <= '0;
    end else begin
      case (r_state)
        ACC: begin
          if (w_accept) begin
            r_sum   <= w_sum_nxt;
            r_carry <= w_carry_nxt;
            r_cnt   <= w_cnt_nxt;
            if (in_last) begin
              r_state    <= RESOLVE;
              r_in_ready <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          r_out_sum   <= w_resolved;
          r_out_cnt   <= r_cnt;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            r_sum       <= '0;
            r_carry     <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ACC;
          end
        end
        default: begin
          r_state     <= ACC;
          r_sum       <= '0;
          r_carry     <= '0;
          r_cnt       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_csa_accum.sv
// Bench for csa_accum (WIDTH=8, CNT_W=8): directed scenarios plus random
// groups, with expected results queued by the driver and checked by a monitor.
module tb_csa_accum;
  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic [CW-1:0] out_cnt;

  csa_accum #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  s;
    logic [CW-1:0] c;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     failures = 0;
  int     n_out = 0;
  int     ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
  int     m_sum;            // reference: plain integer sum of accepted beats
  int     m_n;              // reference: accepted beats in current group

  logic          p_valid, p_ready, p_rst;
  logic [W-1:0]  p_sum;
  logic [CW-1:0] p_cnt;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic l, input int max_gap);
    int  gap;
    logic acc;
    gap = $urandom_range(0, max_gap);
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = W'($urandom);
      in_last  = 1'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    acc = 1'b0;
    for (int k = 0; k < 200; k++) begin
      acc = in_ready;
      tick();
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected accept within 200 cycles");
    end else begin
      m_sum = m_sum + int'(d);
      m_n++;
      if (l) begin
        exp_q.push_back('{s: W'(m_sum % 256), c: CW'((m_n > 255) ? 255 : m_n)});
        m_sum = 0;
        m_n   = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    m_sum = 0;
    m_n   = 0;
  endtask

  task automatic wait_valid(input string nm);
    for (int k = 0; k < 50; k++) begin
      if (out_valid) break;
      tick();
    end
    chk(nm, 32'(out_valid), 32'd1);
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic monitor_step();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      chk("valid_ready_exclusive", 32'(out_valid & in_ready), 32'd0);
      if (p_valid && !p_ready && !p_rst) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_sum", 32'(out_sum), 32'(p_sum));
        chk("hold_cnt", 32'(out_cnt), 32'(p_cnt));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got sum=0x%0h cnt=%0d expected no result", out_sum, out_cnt);
        end else begin
          e = exp_q.pop_front();
          chk("out_sum", 32'(out_sum), 32'(e.s));
          chk("out_cnt", 32'(out_cnt), 32'(e.c));
        end
      end
    end
    p_valid = out_valid;
    p_ready = out_ready;
    p_rst   = rst;
    p_sum   = out_sum;
    p_cnt   = out_cnt;
  endtask

  task automatic ready_step();
    tick();
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run_tests();
    int nb;
    int len;
    // Reset values
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic group with latency check
    send_beat(8'h10, 1'b0, 0);
    send_beat(8'h20, 1'b0, 0);
    send_beat(8'h30, 1'b1, 0);
    chk("lat_resolve_valid", 32'(out_valid), 32'd0);
    chk("lat_resolve_ready", 32'(in_ready), 32'd0);
    tick();
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("basic_sum", 32'(out_sum), 32'h60);
    chk("basic_cnt", 32'(out_cnt), 32'd3);
    tick();
    chk("ready_after_out", 32'(in_ready), 32'd1);
    chk("valid_after_out", 32'(out_valid), 32'd0);

    // Modulo wrap
    send_beat(8'hFF, 1'b0, 0);
    send_beat(8'h02, 1'b1, 0);
    repeat (4) send_beat(8'hFF, (exp_q.size() == 0 && m_n == 3), 0);
    drain("drain_wrap");

    // Single-beat group
    send_beat(8'hA5, 1'b1, 0);
    tick();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_sum", 32'(out_sum), 32'hA5);
    chk("single_cnt", 32'(out_cnt), 32'd1);
    drain("drain_single");

    // Backpressure
    ready_mode = 0;
    tick();
    send_beat(8'h01, 1'b0, 0);
    send_beat(8'h02, 1'b1, 0);
    wait_valid("bp_wait_valid");
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_sum", 32'(out_sum), 32'h03);
      tick();
    end
    nb = n_out;
    ready_mode = 1;
    repeat (4) tick();
    chk("bp_one_handshake", 32'(n_out - nb), 32'd1);
    send_beat(8'h07, 1'b1, 0);
    drain("drain_bp");

    // Reset mid-group discards partial sum
    send_beat(8'h40, 1'b0, 0);
    send_beat(8'h40, 1'b0, 0);
    do_reset();
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    send_beat(8'h05, 1'b1, 0);
    drain("drain_midrst");

    // Reset while a result is pending
    ready_mode = 0;
    tick();
    send_beat(8'h11, 1'b1, 0);
    wait_valid("pend_wait_valid");
    do_reset();
    chk("pendrst_valid", 32'(out_valid), 32'd0);
    chk("pendrst_sum", 32'(out_sum), 32'd0);
    chk("pendrst_cnt", 32'(out_cnt), 32'd0);
    ready_mode = 1;
    tick();

    // Counter saturation
    for (int i = 0; i < 300; i++) send_beat(W'($urandom), (i == 299), 0);
    drain("drain_sat");

    // Random groups
    ready_mode = 2;
    for (int g = 0; g < 1000; g++) begin
      len = $urandom_range(1, 20);
      for (int b = 0; b < len; b++) send_beat(W'($urandom), (b == len - 1), 2);
    end
    ready_mode = 1;
    drain("drain_random");
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    out_ready = 1'b0;
    m_sum = 0;
    m_n   = 0;
    p_valid = 1'b0;
    p_ready = 1'b0;
    p_rst   = 1'b1;
    p_sum   = '0;
    p_cnt   = '0;
    fork
      forever monitor_step();
      forever ready_step();
      begin
        run_tests();
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    join
  end
endmodule
